traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have parameter MIN_GREEN, default 4, meaning the minimum legal green dwell in cycles.
REQ-002 The block SHALL have parameter YELLOW_CYCLES, default 2, meaning the exact legal yellow dwell in cycles.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of the dwell counters.
REQ-004 The block SHALL have a single clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  monitoring enable.
REQ-008 err_clr  in  1  synchronous clear of all sticky error flags.
REQ-009 road1, road2, road3  in  4 each  light codes driven by the traffic-light controller.
REQ-010 conflict  out  1  sticky: more than one road showing green or yellow.
REQ-011 seq_err  out  3  sticky per road (bit0 = road1): illegal colour transition.
REQ-012 code_err  out  3  sticky per road: illegal light code.
REQ-013 timing_err  out  3  sticky per road: dwell rule violated.
REQ-014 active_road  out  2  road in green/yellow: 0 = none, 1..3 = road index.
REQ-015 green_cnt  out  CNT_W  dwell count of the active road.
REQ-016 rotations  out  8  count of road1 red-to-green transitions.

Function
REQ-017 Codes SHALL be RED=4'b0001, YELLOW=4'b0010, GREEN=4'b0100; any other value is illegal.
REQ-018 Each road SHALL be tracked by an FSM with states UNK, RED, GREEN, YELLOW plus a dwell counter.
REQ-019 When en=1, inputs SHALL be sampled on each clk edge; all outputs are registered and reflect the sample with 1-cycle latency.
REQ-020 From UNK, the first legal code SHALL load the matching state with dwell=1 and no sequence or timing check.
REQ-021 Legal transitions SHALL be hold, RED->GREEN, GREEN->YELLOW and YELLOW->RED; any other change sets that road's seq_err bit and the FSM adopts the new state.
REQ-022 An illegal code SHALL set code_err for that road and leave its FSM state and dwell unchanged.
REQ-023 The dwell counter SHALL reset to 1 on any state entry, increment on hold, and saturate at 2^CNT_W-1.
REQ-024 On GREEN->YELLOW with dwell < MIN_GREEN, the block SHALL set timing_err for that road.
REQ-025 On YELLOW->RED with dwell != YELLOW_CYCLES, the block SHALL set timing_err for that road.
REQ-026 conflict SHALL be set when two or more sampled legal codes are GREEN or YELLOW.
REQ-027 active_road SHALL be the lowest-numbered road in GREEN or YELLOW, otherwise 0; green_cnt SHALL be that road's dwell, otherwise 0.
REQ-028 rotations SHALL increment on each road1 RED->GREEN transition and wrap 255->0.
REQ-029 err_clr=1 SHALL clear all sticky flags; if an error is detected in the same cycle, set wins.
REQ-030 When en=0, all state, counters and flags SHALL hold and no checks SHALL run; err_clr still acts.

Reset
REQ-031 On rst=0, all FSMs SHALL go to UNK, dwell to 0, and every output to 0, immediately and independently of clk.
REQ-032 Reset asserted mid-phase SHALL discard history; after release, REQ-020 applies.

Configuration
REQ-033 With TRAFFIC_LIGHT_MONITOR_TIMING_CHECK_EN defined, REQ-024/025 SHALL be active; when it is undefined, timing_err SHALL be constant 0 and the timing comparators SHALL be omitted (dwell counters are kept for green_cnt).

Structure
REQ-034 Package traffic_light_pkg SHALL hold the light-code constants and the road-state enum (UNK, RED, GREEN, YELLOW).
REQ-035 Sub-module tl_road_tracker (FSM, dwell counter, per-road seq/code/timing detect) SHALL be instantiated three times; the conflict, arbitration and rotation logic stays in the top level.

Verification (MIN_GREEN=4, YELLOW_CYCLES=2, CNT_W=8)
REQ-036 Stimulus: legal cycle, road1 G5,Y2,R while road2 and road3 are R, then road2 G5,Y2 -> all flags 0, active_road 1 then 2, rotations=1.
REQ-037 Stimulus: road1 GREEN and road2 YELLOW in the same cycle -> conflict=1 on the next edge and it stays 1 until err_clr.
REQ-038 Stimulus: road3 RED->YELLOW -> seq_err=3'b100; road3 GREEN for 3 cycles then YELLOW -> timing_err[2]=1 (0 when the macro is undefined).
REQ-039 Stimulus: road2 = 4'b0011 for one cycle -> code_err=3'b010, and road2's state/dwell are unchanged afterwards.
REQ-040 Stimulus: err_clr and a new seq error in the same cycle -> that flag remains 1; err_clr alone -> flags 0.
REQ-041 Stimulus: rst=0 asserted mid-green with en toggled -> outputs 0 without a clock edge; en=0 holds green_cnt; after release, the first sample produces no errors.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared light codes and per-road state type for the traffic-light monitor.
package traffic_light_pkg;

  localparam logic [3:0] CodeRed    = 4'b0001;
  localparam logic [3:0] CodeYellow = 4'b0010;
  localparam logic [3:0] CodeGreen  = 4'b0100;

  typedef enum logic [1:0] {
    StUnk,
    StRed,
    StGreen,
    StYellow
  } road_state_e;

  // A road is "lit" when it is granted right of way (green or yellow).
  function automatic logic is_lit(road_state_e st);
    return (st == StGreen) || (st == StYellow);
  endfunction

endpackage

// File: rtl/tl_road_tracker.sv
// Per-road tracker: colour FSM, dwell counter and sticky seq/code/timing flags.
// Timing checks are compiled in only with TRAFFIC_LIGHT_MONITOR_TIMING_CHECK_EN.
module tl_road_tracker
  import traffic_light_pkg::*;
#(
  parameter int unsigned MIN_GREEN     = 4,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             err_clr,
  input  logic [3:0]       code,
  output road_state_e      state_nxt,
  output logic [CNT_W-1:0] dwell_nxt,
  output logic             red_to_green,
  output logic             seq_err,
  output logic             code_err,
  output logic             timing_err
);

  road_state_e      state_q, state_d, code_st;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             code_ok, legal, seq_det, code_det;

  // Decode the sampled light code into a state; anything else is illegal.
  always_comb begin
    code_ok = 1'b1;
    code_st = StUnk;
    case (code)
      CodeRed:    code_st = StRed;
      CodeYellow: code_st = StYellow;
      CodeGreen:  code_st = StGreen;
      default:    code_ok = 1'b0;
    endcase
  end

  // Next state and dwell: illegal codes and en=0 leave both untouched.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (en && code_ok) begin
      if (state_q == StUnk || code_st != state_q) begin
        state_d = code_st;
        dwell_d = CNT_W'(1);
      end else if (dwell_q != '1) begin
        dwell_d = dwell_q + CNT_W'(1);
      end
    end
  end

  // Error detection and road1 rotation pulse; nothing is checked out of UNK.
  always_comb begin
    legal        = 1'b1;
    seq_det      = 1'b0;
    code_det     = 1'b0;
    red_to_green = 1'b0;
    if (en) begin
      code_det = !code_ok;
      if (code_ok && state_q != StUnk && code_st != state_q) begin
        legal = (state_q == StRed    && code_st == StGreen)  ||
                (state_q == StGreen  && code_st == StYellow) ||
                (state_q == StYellow && code_st == StRed);
        seq_det      = !legal;
        red_to_green = (state_q == StRed) && (code_st == StGreen);
      end
    end
  end

  // FSM state, dwell counter and sticky flags; a detect in the clear cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StUnk;
      dwell_q  <= '0;
      seq_err  <= 1'b0;
      code_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      seq_err  <= (seq_err & ~err_clr) | seq_det;
      code_err <= (code_err & ~err_clr) | code_det;
    end
  end

`ifdef TRAFFIC_LIGHT_MONITOR_TIMING_CHECK_EN
  logic timing_det;

  // Dwell rules judged on the dwell accumulated before the transition.
  always_comb begin
    timing_det = 1'b0;
    if (en && code_ok && state_q != StUnk) begin
      if (state_q == StGreen && code_st == StYellow && dwell_q < CNT_W'(MIN_GREEN)) begin
        timing_det = 1'b1;
      end
      if (state_q == StYellow && code_st == StRed && dwell_q != CNT_W'(YELLOW_CYCLES)) begin
        timing_det = 1'b1;
      end
    end
  end

  // Sticky timing flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timing_err <= 1'b0;
    end else begin
      timing_err <= (timing_err & ~err_clr) | timing_det;
    end
  end
`else
  // Dwell limits have no consumer when timing checks are compiled out.
  logic [31:0] unused_timing_cfg;
  assign unused_timing_cfg = MIN_GREEN + YELLOW_CYCLES;
  assign timing_err = 1'b0;
`endif

  assign state_nxt = state_d;
  assign dwell_nxt = dwell_d;

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic-light monitor: three road trackers plus conflict, arbitration and
// rotation logic. Define TRAFFIC_LIGHT_MONITOR_TIMING_CHECK_EN to enable dwell checks.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned MIN_GREEN     = 4,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             err_clr,
  input  logic [3:0]       road1,
  input  logic [3:0]       road2,
  input  logic [3:0]       road3,
  output logic             conflict,
  output logic [2:0]       seq_err,
  output logic [2:0]       code_err,
  output logic [2:0]       timing_err,
  output logic [1:0]       active_road,
  output logic [CNT_W-1:0] green_cnt,
  output logic [7:0]       rotations
);

  logic [2:0][3:0]  codes;
  road_state_e      st_nxt [3];
  logic [CNT_W-1:0] dw_nxt [3];
  logic [2:0]       r2g, lit;
  logic             two_lit;
  logic [1:0]       active_d;
  logic [CNT_W-1:0] cnt_d;

  assign codes = {road3, road2, road1};

  for (genvar i = 0; i < 3; i++) begin : g_road
    tl_road_tracker #(
      .MIN_GREEN    (MIN_GREEN),
      .YELLOW_CYCLES(YELLOW_CYCLES),
      .CNT_W        (CNT_W)
    ) u_tracker (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .err_clr     (err_clr),
      .code        (codes[i]),
      .state_nxt   (st_nxt[i]),
      .dwell_nxt   (dw_nxt[i]),
      .red_to_green(r2g[i]),
      .seq_err     (seq_err[i]),
      .code_err    (code_err[i]),
      .timing_err  (timing_err[i])
    );
  end

  // Only road1 rotations are counted.
  logic unused_r2g;
  assign unused_r2g = ^r2g[2:1];

  // Conflict looks at raw sampled codes, not tracker state.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lit[i] = (codes[i] == CodeGreen) || (codes[i] == CodeYellow);
    end
    two_lit = (lit[0] & lit[1]) | (lit[0] & lit[2]) | (lit[1] & lit[2]);
  end

  // Lowest-numbered lit road wins; evaluated on the states being loaded this edge.
  always_comb begin
    active_d = 2'd0;
    cnt_d    = '0;
    if (is_lit(st_nxt[0])) begin
      active_d = 2'd1;
      cnt_d    = dw_nxt[0];
    end else if (is_lit(st_nxt[1])) begin
      active_d = 2'd2;
      cnt_d    = dw_nxt[1];
    end else if (is_lit(st_nxt[2])) begin
      active_d = 2'd3;
      cnt_d    = dw_nxt[2];
    end
  end

  // Registered top-level outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict    <= 1'b0;
      active_road <= 2'd0;
      green_cnt   <= '0;
      rotations   <= 8'd0;
    end else begin
      conflict    <= (conflict & ~err_clr) | (en & two_lit);
      active_road <= active_d;
      green_cnt   <= cnt_d;
      if (r2g[0]) begin
        rotations <= rotations + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor (MIN_GREEN=4, YELLOW_CYCLES=2, CNT_W=8).
module tb_traffic_light_monitor;

  localparam logic [3:0] LR = 4'b0001;
  localparam logic [3:0] LY = 4'b0010;
  localparam logic [3:0] LG = 4'b0100;
`ifdef TRAFFIC_LIGHT_MONITOR_TIMING_CHECK_EN
  localparam bit TimingOn = 1'b1;
`else
  localparam bit TimingOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, err_clr;
  logic [3:0] road1, road2, road3;
  logic       conflict;
  logic [2:0] seq_err, code_err, timing_err;
  logic [1:0] active_road;
  logic [7:0] green_cnt, rotations;

  int checks = 0;
  int passed = 0;

  traffic_light_monitor #(
    .MIN_GREEN    (4),
    .YELLOW_CYCLES(2),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .err_clr    (err_clr),
    .road1      (road1),
    .road2      (road2),
    .road3      (road3),
    .conflict   (conflict),
    .seq_err    (seq_err),
    .code_err   (code_err),
    .timing_err (timing_err),
    .active_road(active_road),
    .green_cnt  (green_cnt),
    .rotations  (rotations)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    road1 = a;
    road2 = b;
    road3 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; err_clr = 1'b0;
    road1 = 4'h0; road2 = 4'h0; road3 = 4'h0;
    #3;
    checks++;
    if ({conflict, seq_err, code_err, timing_err} !== 10'd0)
      $display("FAIL reset_flags: got %b want 0", {conflict, seq_err, code_err, timing_err});
    else passed++;
    checks++;
    if ({active_road, green_cnt, rotations} !== 18'd0)
      $display("FAIL reset_counts: got %h want 0", {active_road, green_cnt, rotations});
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
  endtask

  task automatic test_legal_cycle();
    step(LR, LR, LR);
    checks++;
    if (active_road !== 2'd0) $display("FAIL legal_idle_active: got %0d want 0", active_road);
    else passed++;
    step(LG, LR, LR);
    checks++;
    if ({active_road, green_cnt, rotations} !== {2'd1, 8'd1, 8'd1})
      $display("FAIL legal_r1_green_entry: got %0d/%0d/%0d want 1/1/1",
               active_road, green_cnt, rotations);
    else passed++;
    repeat (4) step(LG, LR, LR);
    checks++;
    if (green_cnt !== 8'd5) $display("FAIL legal_r1_dwell: got %0d want 5", green_cnt);
    else passed++;
    repeat (2) step(LY, LR, LR);
    checks++;
    if ({active_road, green_cnt} !== {2'd1, 8'd2})
      $display("FAIL legal_r1_yellow: got %0d/%0d want 1/2", active_road, green_cnt);
    else passed++;
    step(LR, LR, LR);
    repeat (5) step(LR, LG, LR);
    checks++;
    if ({active_road, green_cnt} !== {2'd2, 8'd5})
      $display("FAIL legal_r2_green: got %0d/%0d want 2/5", active_road, green_cnt);
    else passed++;
    repeat (2) step(LR, LY, LR);
    step(LR, LR, LR);
    checks++;
    if ({conflict, seq_err, code_err, timing_err} !== 10'd0)
      $display("FAIL legal_no_flags: got %b want 0", {conflict, seq_err, code_err, timing_err});
    else passed++;
    checks++;
    if ({active_road, rotations} !== {2'd0, 8'd1})
      $display("FAIL legal_end: got %0d/%0d want 0/1", active_road, rotations);
    else passed++;
  endtask

  task automatic test_conflict();
    step(LG, LY, LR);
    checks++;
    if ({conflict, seq_err, active_road, rotations} !== {1'b1, 3'b010, 2'd1, 8'd2})
      $display("FAIL conflict_set: got %b/%b/%0d/%0d want 1/010/1/2",
               conflict, seq_err, active_road, rotations);
    else passed++;
    step(LR, LR, LR);
    checks++;
    if ({conflict, seq_err} !== {1'b1, 3'b011})
      $display("FAIL conflict_sticky: got %b/%b want 1/011", conflict, seq_err);
    else passed++;
    checks++;
    if (timing_err !== (TimingOn ? 3'b010 : 3'b000))
      $display("FAIL conflict_r2_yellow_short: got %b want %b", timing_err,
               (TimingOn ? 3'b010 : 3'b000));
    else passed++;
    step(LR, LR, LR);
    checks++;
    if (conflict !== 1'b1) $display("FAIL conflict_hold: got %b want 1", conflict);
    else passed++;
    err_clr = 1'b1;
    step(LR, LR, LR);
    err_clr = 1'b0;
    checks++;
    if ({conflict, seq_err, timing_err} !== 7'd0)
      $display("FAIL conflict_clear: got %b want 0", {conflict, seq_err, timing_err});
    else passed++;
  endtask

  task automatic test_seq_timing();
    step(LR, LR, LY);
    checks++;
    if ({seq_err, active_road} !== {3'b100, 2'd3})
      $display("FAIL seq_r3_red_yellow: got %b/%0d want 100/3", seq_err, active_road);
    else passed++;
    step(LR, LR, LY);
    err_clr = 1'b1;
    step(LR, LR, LR);
    err_clr = 1'b0;
    checks++;
    if ({seq_err, timing_err} !== 6'd0)
      $display("FAIL seq_cleared: got %b want 0", {seq_err, timing_err});
    else passed++;
    repeat (3) step(LR, LR, LG);
    checks++;
    if ({active_road, green_cnt} !== {2'd3, 8'd3})
      $display("FAIL timing_r3_green3: got %0d/%0d want 3/3", active_road, green_cnt);
    else passed++;
    step(LR, LR, LY);
    checks++;
    if ({seq_err, timing_err} !== {3'b000, (TimingOn ? 3'b100 : 3'b000)})
      $display("FAIL timing_short_green: got %b/%b want 000/%b", seq_err, timing_err,
               (TimingOn ? 3'b100 : 3'b000));
    else passed++;
    step(LR, LR, LY);
    step(LR, LR, LR);
    err_clr = 1'b1;
    step(LR, LR, LR);
    err_clr = 1'b0;
    checks++;
    if (timing_err !== 3'b000) $display("FAIL timing_cleared: got %b want 000", timing_err);
    else passed++;
  endtask

  task automatic test_code_err();
    repeat (2) step(LR, LG, LR);
    step(LR, 4'b0011, LR);
    checks++;
    if ({code_err, active_road, green_cnt} !== {3'b010, 2'd2, 8'd2})
      $display("FAIL code_illegal: got %b/%0d/%0d want 010/2/2",
               code_err, active_road, green_cnt);
    else passed++;
    step(LR, LG, LR);
    checks++;
    if ({seq_err, green_cnt} !== {3'b000, 8'd3})
      $display("FAIL code_state_kept: got %b/%0d want 000/3", seq_err, green_cnt);
    else passed++;
    step(LR, LG, LR);
    repeat (2) step(LR, LY, LR);
    step(LR, LR, LR);
    checks++;
    if ({code_err, seq_err, timing_err} !== {3'b010, 6'd0})
      $display("FAIL code_sticky: got %b want 010000000", {code_err, seq_err, timing_err});
    else passed++;
  endtask

  task automatic test_set_wins();
    err_clr = 1'b1;
    step(LY, LR, LR);
    err_clr = 1'b0;
    checks++;
    if ({seq_err, code_err} !== {3'b001, 3'b000})
      $display("FAIL set_wins: got %b/%b want 001/000", seq_err, code_err);
    else passed++;
    step(LY, LR, LR);
    step(LR, LR, LR);
    err_clr = 1'b1;
    step(LR, LR, LR);
    err_clr = 1'b0;
    checks++;
    if ({conflict, seq_err, code_err, timing_err} !== 10'd0)
      $display("FAIL clear_alone: got %b want 0", {conflict, seq_err, code_err, timing_err});
    else passed++;
  endtask

  task automatic test_reset_mid();
    repeat (3) step(LG, LR, LR);
    checks++;
    if ({green_cnt, rotations} !== {8'd3, 8'd3})
      $display("FAIL mid_green: got %0d/%0d want 3/3", green_cnt, rotations);
    else passed++;
    en = 1'b0;
    step(LY, LR, LR);
    step(4'hF, LY, LR);
    checks++;
    if ({active_road, green_cnt} !== {2'd1, 8'd3})
      $display("FAIL en_low_hold: got %0d/%0d want 1/3", active_road, green_cnt);
    else passed++;
    checks++;
    if ({conflict, seq_err, code_err, timing_err} !== 10'd0)
      $display("FAIL en_low_no_check: got %b want 0", {conflict, seq_err, code_err, timing_err});
    else passed++;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({active_road, green_cnt, rotations} !== 18'd0)
      $display("FAIL async_reset: got %h want 0", {active_road, green_cnt, rotations});
    else passed++;
    en = 1'b1;
    #1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    step(LY, LR, LR);
    checks++;
    if ({seq_err, timing_err, code_err, conflict} !== 10'd0)
      $display("FAIL post_reset_first_sample: got %b want 0",
               {seq_err, timing_err, code_err, conflict});
    else passed++;
    checks++;
    if ({active_road, green_cnt, rotations} !== {2'd1, 8'd1, 8'd0})
      $display("FAIL post_reset_load: got %0d/%0d/%0d want 1/1/0",
               active_road, green_cnt, rotations);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_seq_timing();
    test_code_err();
    test_set_wins();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
